// File: rtl/reg_wr_arbiter.sv
// reg_wr_arbiter: round-robin arbiter for the write port of one shared
// WIDTH-bit register. The handshake is combinational within a cycle: a
// requester holds req[i] until it sees gnt[i]. The cycle where both are
// high is the transfer; the winner's data appears on reg_we/reg_d one
// cycle later.
// Optional build macro REG_ARB_LOCK_EN adds a 'lock' input. With it, the
// winner can keep the port for later transfers until it sends a transfer
// with lock=0.
module reg_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  input  logic                  hold,
`ifdef REG_ARB_LOCK_EN
  input  logic                  lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic                  reg_we,
  output logic [WIDTH-1:0]      reg_d,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    ptr_q, ptr_d;
  logic             reg_we_q, reg_we_d;
  logic [WIDTH-1:0] reg_d_q, reg_d_d;
`ifdef REG_ARB_LOCK_EN
  logic             lock_valid_q, lock_valid_d;
  logic [PW-1:0]    lock_owner_q, lock_owner_d;
`endif

  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    next_ptr;
  logic [PW-1:0]    scan_idx;
  logic [WIDTH-1:0] win_data;
  logic             found;
  logic             xfer;
  int               idx;

  // Grant: first request at or after the pointer (wrapping), or only the lock owner while locked.
  always_comb begin
    gnt      = '0;
    win_idx  = '0;
    found    = 1'b0;
    idx      = 0;
    scan_idx = '0;
    if (rst && !hold) begin
`ifdef REG_ARB_LOCK_EN
      if (lock_valid_q) begin
        if (req[lock_owner_q]) begin
          gnt[lock_owner_q] = 1'b1;
          win_idx           = lock_owner_q;
        end
      end else begin
`else
      begin
`endif
        for (int off = 0; off < NREQ; off++) begin
          idx = int'(ptr_q) + off;
          if (idx >= NREQ) idx = idx - NREQ;
          scan_idx = PW'(idx);
          if (!found && req[scan_idx]) begin
            found         = 1'b1;
            gnt[scan_idx] = 1'b1;
            win_idx       = scan_idx;
          end
        end
      end
    end
  end

  // Winner's data: one-hot OR-mux of the write-data slices.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) win_data = win_data | wdata[i*WIDTH +: WIDTH];
    end
  end

  // Next-state: pointer advance, lock bookkeeping and output stage.
  always_comb begin
    xfer     = |gnt;
    next_ptr = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
    ptr_d    = ptr_q;
    reg_we_d = xfer;
    reg_d_d  = xfer ? win_data : reg_d_q;
`ifdef REG_ARB_LOCK_EN
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    if (xfer) begin
      if (lock) begin
        // Pointer stays put while the port is locked.
        lock_valid_d = 1'b1;
        lock_owner_d = win_idx;
      end else begin
        lock_valid_d = 1'b0;
        ptr_d        = next_ptr;
      end
    end
`else
    if (xfer) ptr_d = next_ptr;
`endif
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q        <= '0;
      reg_we_q     <= 1'b0;
      reg_d_q      <= '0;
`ifdef REG_ARB_LOCK_EN
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
`endif
    end else begin
      ptr_q        <= ptr_d;
      reg_we_q     <= reg_we_d;
      reg_d_q      <= reg_d_d;
`ifdef REG_ARB_LOCK_EN
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
`endif
    end
  end

  assign reg_we = reg_we_q;
  assign reg_d  = reg_d_q;
  assign busy   = (|req) & ~(|gnt);

endmodule
